instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 9-bit, 3-bit-opcode core. Holds the program counter, issues sequential reads to a synchronous instruction memory, buffers returned instructions in a 2-entry queue, and presents them to the decode/control stage over a valid/ready handshake. Taken branches (bnez) redirect fetch and squash in-flight and buffered instructions; the halt request stops fetching.

## Interface
- PC_W, 10: program counter and instruction memory address width.
- INSTR_W, 9: instruction width; opcode is bits [INSTR_W-1 -: 3].
- RESET_PC, 0: fetch start address after reset and after start.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins fetching at RESET_PC from IDLE or HALTED.
- halt  in  1  stop fetching, flush, enter HALTED.
- branch_taken  in  1  redirect request from the branch-resolve logic.
- branch_target  in  PC_W  redirect address, valid with branch_taken.
- imem_req  out  1  read request this cycle.
- imem_addr  out  PC_W  read address, valid with imem_req.
- imem_rdata  in  INSTR_W  read data, valid the cycle after the request.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode accepts head.
- instr_out  out  INSTR_W  head instruction.
- opcode  out  3  instr_out[INSTR_W-1 -: 3], for the control decoder.
- pc_out  out  PC_W  address of the head instruction.
- done  out  1  high while in HALTED.

## Operation
- States: IDLE (reset), FETCH, HALTED.
  - IDLE --start--> FETCH, with pc = RESET_PC.
  - FETCH --halt--> HALTED.
  - HALTED --start--> FETCH, with pc = RESET_PC.
  - start in FETCH is ignored. halt in IDLE or HALTED is ignored.
- Fetch pc register: address of the next request.
- Queue: 2 entries {instr, pc}, FIFO order.
  - count = entries in the queue.
  - inflight = 1 if a request was issued last cycle and not squashed.
- Request rule: imem_req = 1 in FETCH when count + inflight - pop < 2, where pop = instr_valid & instr_ready.
  - imem_addr = pc. On issue, pc <= pc + 1, modulo 2^PC_W (wraps 2^PC_W-1 -> 0).
- Response: when inflight is set, imem_rdata and its request address are pushed into the queue at the end of that cycle.
- Push and pop in the same cycle are allowed. The count never exceeds 2.
- Redirect (branch_taken in FETCH):
  - Clear the queue and drop this cycle's response.
  - Issue imem_req with imem_addr = branch_target in the same cycle; pc <= branch_target + 1.
  - instr_valid deasserts the next cycle.
  - A pop in the redirect cycle still completes, so decode may accept the head while it raises branch_taken.
- Halt: clear the queue, drop the in-flight response, imem_req = 0 that cycle. halt takes priority over branch_taken.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No output glitches to valid.

## Timing
- Reset values:
  - state = IDLE, pc = RESET_PC, count = 0, inflight = 0.
  - instr_valid = 0, instr_out = 0, opcode = 0, pc_out = 0.
  - imem_req = 0, imem_addr = RESET_PC, done = 0.
- In IDLE and HALTED, imem_addr = pc.
- Start latency: start at cycle 0. First imem_req is in cycle 1. First instr_valid is in cycle 3 (response registered in cycle 2).
- Throughput: with instr_ready held high, one instruction per cycle after fill.
- Stall: with instr_ready low, the queue fills to 2 and imem_req stays 0. instr_out and pc_out are stable while instr_valid & !instr_ready.
- Redirect: branch_taken in cycle t. The target instruction is valid in cycle t+2.
- done rises the cycle after halt is sampled. instr_valid is 0 from that cycle.

## Test plan
- Reset/start: release rst_n, pulse start in cycle 0.
  - imem_addr = 0,1,2,... from cycle 1.
  - With instr_ready = 1, pc_out = 0,1,2 in cycles 3,4,5.
  - opcode matches the memory contents.
- Backpressure: hold instr_ready = 0 for 5 cycles mid-stream.
  - Queue holds 2 entries, imem_req = 0.
  - On release, no instruction is lost or duplicated; the pc_out sequence is contiguous.
- Branch: at head pc 5, assert branch_taken with branch_target = 40.
  - Instructions 6 and 7 never appear.
  - pc_out = 40 two cycles later, then 41, 42.
- Wrap: PC_W = 4, fetch past 15; the pc_out sequence is 14, 15, 0, 1.
- Halt priority: assert halt and branch_taken together.
  - done = 1 the next cycle, instr_valid = 0, no imem_req.
  - A later start resumes at RESET_PC.
- Async reset mid-fetch: drop rst_n between clock edges while the queue is full.
  - All outputs are at reset values immediately; fetch restarts only after start.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: PC, sequential imem reads, 2-entry {instr, pc} queue to decode.
// Start-to-valid is 3 cycles, then 1/cycle; a full queue with instr_ready low stops requests.
module instr_fetch #(
    parameter int PC_W     = 10,
    parameter int INSTR_W  = 9,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [2:0]         opcode,
    output logic [PC_W-1:0]    pc_out,
    output logic               done
);

    localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    state_t          state;
    state_t          stateNext;
    logic            fetching;
    logic            launch;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] reqAddr;
    logic            inflight;
    logic [1:0]      count;
    logic [1:0]      countNext;
    logic [2:0]      level;
    entry_t          headEntry;
    entry_t          tailEntry;
    entry_t          respEntry;
    logic            redirect;
    logic            flush;
    logic            pop;
    logic            push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = FETCH;
            FETCH:   if (halt)  stateNext = HALTED;
            HALTED:  if (start) stateNext = FETCH;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        fetching = 1'b0;
        launch   = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    launch = start;
            FETCH:   fetching = 1'b1;
            HALTED:  begin
                done   = 1'b1;
                launch = start;
            end
            default: ;
        endcase
    end

    // halt outranks a same-cycle branch; both empty the queue and kill the response
    assign redirect    = fetching & branch_taken & ~halt;
    assign flush       = fetching & (halt | branch_taken);
    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~flush;
    assign level       = {1'b0, count} + 3'(inflight) - 3'(pop);
    assign imem_req    = fetching & ~halt & (redirect | (level < 3'd2));
    assign imem_addr   = redirect ? branch_target : pc;
    assign countNext   = count + 2'(push) - 2'(pop);
    assign respEntry   = '{instr: imem_rdata, pc: reqAddr};

    assign instr_out = headEntry.instr;
    assign pc_out    = headEntry.pc;
    assign opcode    = headEntry.instr[INSTR_W-1 -: 3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= ResetPc;
            reqAddr   <= ResetPc;
            inflight  <= 1'b0;
            count     <= 2'd0;
            headEntry <= '0;
            tailEntry <= '0;
        end else begin
            if (launch) begin
                pc <= ResetPc;
            end else if (imem_req) begin
                pc <= imem_addr + PC_W'(1);
            end
            if (imem_req) begin
                reqAddr <= imem_addr;
            end
            inflight <= imem_req;
            if (flush) begin
                count <= 2'd0;
            end else begin
                count <= countNext;
                if (pop) begin
                    headEntry <= tailEntry;
                end
                // an entry popped this cycle frees the head slot for the incoming response
                if (push) begin
                    if ((count == 2'd0) || (count == 2'd1 && pop)) begin
                        headEntry <= respEntry;
                    end else begin
                        tailEntry <= respEntry;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: scoreboard of expected head PCs against a synchronous memory model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       branch_taken;
    logic [9:0] branch_target;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic [8:0] imem_rdata = '0;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr_out;
    logic [2:0] opcode;
    logic [9:0] pc_out;
    logic       done;

    logic       wStart;
    logic       wReady;
    logic       wReq;
    logic [3:0] wAddr;
    logic [8:0] wRdata = '0;
    logic       wValid;
    logic [8:0] wInstr;
    logic [2:0] wOpcode;
    logic [3:0] wPc;
    logic       wDone;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int sbq[$];
    int wq[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .opcode(opcode), .pc_out(pc_out), .done(done)
    );

    instr_fetch #(.PC_W(4), .INSTR_W(9), .RESET_PC(12)) wdut (
        .clk(clk), .rst_n(rst_n), .start(wStart), .halt(1'b0),
        .branch_taken(1'b0), .branch_target(4'd0),
        .imem_req(wReq), .imem_addr(wAddr), .imem_rdata(wRdata),
        .instr_valid(wValid), .instr_ready(wReady),
        .instr_out(wInstr), .opcode(wOpcode), .pc_out(wPc), .done(wDone)
    );

    function automatic logic [8:0] memWord(input int a);
        return 9'((a * 53 + 7) ^ (a >> 2));
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memWord(int'(imem_addr));
        if (wReq)     wRdata     <= memWord(int'(wAddr));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        int e;
        logic [8:0] w;
        logic [2:0] op;
        @(negedge clk);
        if (rst_n && instr_valid && instr_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pop_pc", 32'(pc_out), 32'hffff_ffff);
            end else begin
                e  = sbq.pop_front();
                w  = memWord(e);
                op = w[8:6];
                chk("pc_out", 32'(pc_out), 32'(e));
                chk("instr_out", 32'(instr_out), 32'(w));
                chk("opcode", 32'(opcode), 32'(op));
            end
        end
        if (rst_n && wValid && wReady) begin
            if (wq.size() == 0) begin
                chk("wrap_unexpected_pop_pc", 32'(wPc), 32'hffff_ffff);
            end else begin
                e  = wq.pop_front();
                w  = memWord(e);
                op = w[8:6];
                chk("wrap_pc_out", 32'(wPc), 32'(e));
                chk("wrap_instr_out", 32'(wInstr), 32'(w));
                chk("wrap_opcode", 32'(wOpcode), 32'(op));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr_out"}, 32'(instr_out), 32'd0);
        chk({tag, "_opcode"}, 32'(opcode), 32'd0);
        chk({tag, "_pc_out"}, 32'(pc_out), 32'd0);
        chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        branch_target = '0; instr_ready = 1'b0; wStart = 1'b0; wReady = 1'b0;
        #2;
        checkReset("por");
        advance();
        rst_n = 1'b1;

        // start pulse is cycle 0
        start = 1'b1; instr_ready = 1'b1;
        for (int p = 0; p <= 5; p++) sbq.push_back(p);
        step(1);
        start = 1'b0;
        sample(); chk("c1_req", 32'(imem_req), 1); chk("c1_addr", 32'(imem_addr), 0); advance();
        sample(); chk("c2_req", 32'(imem_req), 1); chk("c2_addr", 32'(imem_addr), 1);
        chk("c2_valid", 32'(instr_valid), 0); advance();
        sample(); chk("c3_valid", 32'(instr_valid), 1); chk("c3_addr", 32'(imem_addr), 2); advance();
        step(2);

        // backpressure for 5 cycles with pc 3 at the head
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_req", 32'(imem_req), 0);
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_pc_out", 32'(pc_out), 3);
            advance();
        end
        instr_ready = 1'b1;
        step(2);

        // redirect while pc 5 is accepted
        branch_taken = 1'b1; branch_target = 10'd40;
        sample();
        chk("br_req", 32'(imem_req), 1);
        chk("br_addr", 32'(imem_addr), 40);
        chk("br_pre_left", 32'(sbq.size()), 0);
        advance();
        branch_taken = 1'b0;
        sbq.push_back(40); sbq.push_back(41); sbq.push_back(42);
        sample(); chk("br_next_valid", 32'(instr_valid), 0); advance();
        step(3);
        chk("br_post_left", 32'(sbq.size()), 0);

        // halt together with branch
        instr_ready = 1'b0; halt = 1'b1; branch_taken = 1'b1; branch_target = 10'd100;
        sample(); chk("halt_req", 32'(imem_req), 0); advance();
        halt = 1'b0; branch_taken = 1'b0;
        sample();
        chk("halt_done", 32'(done), 1);
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_req_after", 32'(imem_req), 0);
        advance();
        instr_ready = 1'b1;
        sample(); chk("halted_done", 32'(done), 1); chk("halted_req", 32'(imem_req), 0); advance();

        // restart from HALTED
        start = 1'b1;
        sbq.push_back(0); sbq.push_back(1); sbq.push_back(2);
        step(1);
        start = 1'b0;
        sample();
        chk("restart_req", 32'(imem_req), 1);
        chk("restart_addr", 32'(imem_addr), 0);
        chk("restart_done", 32'(done), 0);
        advance();
        step(4);
        chk("restart_left", 32'(sbq.size()), 0);

        // fill the queue, then reset between edges
        instr_ready = 1'b0;
        step(4);
        chk("prereset_valid", 32'(instr_valid), 1);
        chk("prereset_pc_out", 32'(pc_out), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("arst");
        advance();
        advance();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("idle_req", 32'(imem_req), 0);
            chk("idle_valid", 32'(instr_valid), 0);
            advance();
        end
        start = 1'b1;
        sbq.push_back(0); sbq.push_back(1); sbq.push_back(2);
        step(1);
        start = 1'b0;
        sample(); chk("rst_start_req", 32'(imem_req), 1); chk("rst_start_addr", 32'(imem_addr), 0); advance();
        step(4);
        instr_ready = 1'b0;
        chk("rst_start_left", 32'(sbq.size()), 0);

        // 4-bit PC wraps 15 -> 0
        wStart = 1'b1; wReady = 1'b1;
        wq.push_back(12); wq.push_back(13); wq.push_back(14);
        wq.push_back(15); wq.push_back(0); wq.push_back(1);
        step(1);
        wStart = 1'b0;
        sample(); chk("wrap_req", 32'(wReq), 1); chk("wrap_addr", 32'(wAddr), 12); advance();
        step(7);
        wReady = 1'b0;
        chk("wrap_left", 32'(wq.size()), 0);
        step(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
